// File: rtl/if_stage_fetch_queue.sv
// Instruction fetch stage: in-flight request tracking plus an ID-facing queue.
// Define IF_PERF_CNT_EN to add the fetch/drop performance counters.
module if_stage_fetch_queue #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          FETCH_DEPTH     = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_allow_in,
   output logic        if_to_id_valid,
   output logic [63:0] if_to_id_bus,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_drop_cnt,
`endif
   output logic [31:0] pc,
   output logic        inst_req_valid,
   input  logic        inst_req_ready,
   input  logic [31:0] instruction,
   input  logic        inst_valid,
   output logic        inst_ready
);

   localparam int QAW = $clog2(FETCH_DEPTH);
   localparam int QCW = $clog2(FETCH_DEPTH + 1);
   localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
   localparam int FAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int SW  = QCW + 1;

   localparam logic [OCW-1:0] MAX_O   = OCW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0]  DEPTH_S = SW'(FETCH_DEPTH);
   localparam logic [FAW-1:0] F_LAST  = FAW'(MAX_OUTSTANDING - 1);

   logic [31:0]    fetch_pc_q, fetch_pc_d;
   logic [63:0]    q_mem_q [FETCH_DEPTH];
   logic [63:0]    q_mem_d [FETCH_DEPTH];
   logic [QAW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
   logic [QCW-1:0] q_cnt_q, q_cnt_d;
   logic [31:0]    f_mem_q [MAX_OUTSTANDING];
   logic [31:0]    f_mem_d [MAX_OUTSTANDING];
   logic [FAW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;
   logic [OCW-1:0] out_q, out_d, drop_q, drop_d;

   logic           req_fire, resp_fire, discard, keep, pop;
   logic [SW-1:0]  used;

   assign used           = SW'(out_q) + SW'(q_cnt_q);
   assign inst_req_valid = ~rst & ~redirect_valid & (out_q < MAX_O) & (used < DEPTH_S);
   assign pc             = fetch_pc_q;
   assign inst_ready     = 1'b1;
   assign if_to_id_valid = ~rst & (q_cnt_q != '0) & ~redirect_valid;
   assign if_to_id_bus   = q_mem_q[q_rd_q];

   always_comb begin
      // Responses with nothing in flight are ignored so no counter can underflow.
      resp_fire  = inst_valid & (out_q != '0);
      discard    = resp_fire & (redirect_valid | (drop_q != '0));
      keep       = resp_fire & ~discard;
      req_fire   = inst_req_valid & inst_req_ready;
      pop        = if_to_id_valid & id_allow_in;
      fetch_pc_d = fetch_pc_q;
      q_mem_d    = q_mem_q;
      q_wr_d     = q_wr_q;
      q_rd_d     = q_rd_q;
      f_mem_d    = f_mem_q;
      f_wr_d     = f_wr_q;
      f_rd_d     = f_rd_q;
      drop_d     = drop_q;
      q_cnt_d    = q_cnt_q + QCW'(keep) - QCW'(pop);
      out_d      = out_q + OCW'(req_fire) - OCW'(resp_fire);
      if (req_fire) begin
         f_mem_d[f_wr_q] = fetch_pc_q;
         f_wr_d          = (f_wr_q == F_LAST) ? '0 : f_wr_q + FAW'(1);
         fetch_pc_d      = fetch_pc_q + 32'd4;
      end
      if (keep) begin
         q_mem_d[q_wr_q] = {instruction, f_mem_q[f_rd_q]};
         q_wr_d          = q_wr_q + QAW'(1);
         f_rd_d          = (f_rd_q == F_LAST) ? '0 : f_rd_q + FAW'(1);
      end
      if (pop) q_rd_d = q_rd_q + QAW'(1);
      if (resp_fire && drop_q != '0) drop_d = drop_q - OCW'(1);
      // Everything still in flight after this cycle belongs to the old path.
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         q_wr_d     = '0;
         q_rd_d     = '0;
         q_cnt_d    = '0;
         f_wr_d     = '0;
         f_rd_d     = '0;
         drop_d     = out_q - OCW'(resp_fire);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         q_wr_q     <= '0;
         q_rd_q     <= '0;
         q_cnt_q    <= '0;
         f_wr_q     <= '0;
         f_rd_q     <= '0;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         q_wr_q     <= q_wr_d;
         q_rd_q     <= q_rd_d;
         q_cnt_q    <= q_cnt_d;
         f_wr_q     <= f_wr_d;
         f_rd_q     <= f_rd_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      q_mem_q <= q_mem_d;
      f_mem_q <= f_mem_d;
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_q, perf_fetch_d, perf_drop_q, perf_drop_d;

   always_comb begin
      perf_fetch_d = perf_fetch_q + 32'(pop);
      perf_drop_d  = perf_drop_q + 32'(discard);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q <= '0;
         perf_drop_q  <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_drop_q  <= perf_drop_d;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_drop_cnt  = perf_drop_q;
`endif

endmodule

// File: tb/tb_if_stage_fetch_queue.sv
// Directed bench for if_stage_fetch_queue with an in-order 1-cycle memory model.
// Perf counter checks are included when IF_PERF_CNT_EN is defined.
module tb_if_stage_fetch_queue;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_allow_in;
   logic        if_to_id_valid;
   logic [63:0] if_to_id_bus;
   logic [31:0] pc;
   logic        inst_req_valid;
   logic        inst_req_ready;
   logic [31:0] instruction;
   logic        inst_valid;
   logic        inst_ready;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_drop_cnt;
`endif

   int          total;
   int          bad;
   int          cyc;
   int          first_v;
   logic        hold;
   logic [31:0] mq[$];
   logic [31:0] rx_pc[$];

   if_stage_fetch_queue dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_allow_in    (id_allow_in),
      .if_to_id_valid (if_to_id_valid),
      .if_to_id_bus   (if_to_id_bus),
`ifdef IF_PERF_CNT_EN
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_drop_cnt  (perf_drop_cnt),
`endif
      .pc             (pc),
      .inst_req_valid (inst_req_valid),
      .inst_req_ready (inst_req_ready),
      .instruction    (instruction),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'h5A5A_1234;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic        rf;
      logic        vf;
      logic        rs;
      logic [31:0] ps;
      inst_valid  = !hold && (mq.size() > 0);
      instruction = (mq.size() > 0) ? memf(mq[0]) : 32'h0;
      #1;
      if (if_to_id_valid && id_allow_in) begin
         rx_pc.push_back(if_to_id_bus[31:0]);
         check("inst", {32'h0, if_to_id_bus[63:32]}, {32'h0, memf(if_to_id_bus[31:0])});
      end
      if (if_to_id_valid && first_v < 0) first_v = cyc;
      rf = inst_req_valid & inst_req_ready;
      vf = inst_valid;
      rs = rst;
      ps = pc;
      @(posedge clk);
      #1;
      if (rs) mq.delete();
      else begin
         if (vf) void'(mq.pop_front());
         if (rf) mq.push_back(ps);
      end
      cyc++;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      hold           = 1'b0;
      tick();
      tick();
      check("rst_req_valid", {63'h0, inst_req_valid}, 64'h0);
      check("rst_id_valid", {63'h0, if_to_id_valid}, 64'h0);
      check("rst_pc", {32'h0, pc}, 64'h0);
      check("rst_inst_ready", {63'h0, inst_ready}, 64'h1);
      rst = 1'b0;
      rx_pc.delete();
      cyc     = 0;
      first_v = -1;
   endtask

   task automatic expect_rx(input string tag, input int idx, input logic [31:0] exp);
      logic [31:0] obs;
      obs = (idx < rx_pc.size()) ? rx_pc[idx] : ~exp;
      check(tag, {32'h0, obs}, {32'h0, exp});
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      cyc            = 0;
      first_v        = -1;
      hold           = 1'b0;
      inst_req_ready = 1'b1;
      id_allow_in    = 1'b1;
      inst_valid     = 1'b0;
      instruction    = 32'h0;

      // streaming: first ID word two cycles after first request
      do_reset();
      repeat (8) tick();
      check("first_lat", 64'(first_v), 64'd2);
      check("stream_n", 64'(rx_pc.size()), 64'd6);
      for (int i = 0; i < 6; i++) expect_rx("stream_pc", i, 32'(i * 4));
`ifdef IF_PERF_CNT_EN
      check("perf_fetch", {32'h0, perf_fetch_cnt}, 64'd6);
      check("perf_drop0", {32'h0, perf_drop_cnt}, 64'd0);
`endif

      // ID stall fills the queue to FETCH_DEPTH
      do_reset();
      id_allow_in = 1'b0;
      repeat (10) tick();
      check("full_req_valid", {63'h0, inst_req_valid}, 64'h0);
      check("full_id_valid", {63'h0, if_to_id_valid}, 64'h1);
      check("full_pc", {32'h0, pc}, 64'h10);
      id_allow_in = 1'b1;
      repeat (6) tick();
      for (int i = 0; i < 5; i++) expect_rx("full_pc_order", i, 32'(i * 4));

      // redirect with two requests outstanding
      do_reset();
      hold           = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h10;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      check("maxout_req_valid", {63'h0, inst_req_valid}, 64'h0);
      check("maxout_pc", {32'h0, pc}, 64'h18);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      #1;
      check("redir_req_valid", {63'h0, inst_req_valid}, 64'h0);
      tick();
      redirect_valid = 1'b0;
      hold           = 1'b0;
      repeat (6) tick();
      expect_rx("redir100_pc0", 0, 32'h100);
      expect_rx("redir100_pc1", 1, 32'h104);
`ifdef IF_PERF_CNT_EN
      check("perf_drop_100", {32'h0, perf_drop_cnt}, 64'd2);
`endif

      // response lands in the redirect cycle
      do_reset();
      hold = 1'b1;
      tick();
      tick();
      hold           = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      tick();
      redirect_valid = 1'b0;
      repeat (6) tick();
      expect_rx("redir200_pc0", 0, 32'h200);
      expect_rx("redir200_pc1", 1, 32'h204);
`ifdef IF_PERF_CNT_EN
      check("perf_drop_200", {32'h0, perf_drop_cnt}, 64'd2);
`endif

      // back-to-back redirects
      do_reset();
      hold = 1'b1;
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      tick();
      redirect_pc    = 32'h400;
      tick();
      redirect_valid = 1'b0;
      hold           = 1'b0;
      repeat (7) tick();
      expect_rx("b2b_pc0", 0, 32'h400);
      expect_rx("b2b_pc1", 1, 32'h404);
      expect_rx("b2b_pc2", 2, 32'h408);

      // fetch address wraps past the top of memory
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      tick();
      check("wrap_pc", {32'h0, pc}, 64'h0);
      repeat (4) tick();
      expect_rx("wrap_rx0", 0, 32'hFFFF_FFFC);
      expect_rx("wrap_rx1", 1, 32'h0);

      // reset in the middle of traffic
      repeat (3) tick();
      do_reset();
      check("midrst_pc", {32'h0, pc}, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_stage_fetch_queue.md
Name: if_stage_fetch_queue

Overview:
Parametrised next-generation instruction-fetch stage for the custom CPU pipeline.
- Keeps up to MAX_OUTSTANDING instruction requests in flight.
- Buffers returned instructions in a FETCH_DEPTH-entry queue ahead of ID.
- On a branch/jump redirect it flushes the queue and silently discards stale in-flight responses.
- Sits between the instruction memory request/response channels and the ID stage; presents {instruction, pc} to ID.

Parameters:
RESET_PC, 32'h00000000, address of the first fetch after reset
FETCH_DEPTH, 4, instruction queue entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (1..FETCH_DEPTH)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
redirect_valid  input  1  branch/jump taken this cycle
redirect_pc  input  32  redirect target
id_allow_in  input  1  ID can accept an instruction
if_to_id_valid  output  1  head queue entry valid for ID
if_to_id_bus  output  64  {instruction[31:0], pc[31:0]} of head entry
pc  output  32  request address
inst_req_valid  output  1  request valid
inst_req_ready  input  1  memory accepts request
instruction  input  32  response data
inst_valid  input  1  response valid
inst_ready  output  1  IF accepts response

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values: fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, inst_req_valid=0, if_to_id_valid=0, inst_ready=1, pc=RESET_PC.
- Request issue:
  - inst_req_valid = ~rst & ~redirect_valid & (outstanding < MAX_OUTSTANDING) & (outstanding + occupancy < FETCH_DEPTH).
  - pc = fetch_pc.
  - On handshake: fetch_pc += 4 (mod 2^32, wraps 32'hFFFFFFFC -> 0); push the request pc into the in-flight PC FIFO (depth MAX_OUTSTANDING); outstanding++.
- Responses are returned in order. inst_ready is constantly 1, because issue reserves a queue slot.
- On response handshake, outstanding-- and one of:
  - drop_cnt > 0: discard the data, pop the in-flight PC, drop_cnt--.
  - drop_cnt == 0: push {instruction, popped pc} into the queue.
- Request, response and ID pop in the same cycle: all counters update net; the queue never overflows.
- ID handoff:
  - if_to_id_valid = queue non-empty & ~redirect_valid.
  - Pop when if_to_id_valid & id_allow_in.
  - Latency: a response accepted in cycle N is visible to ID at cycle N+1 (registered queue, no bypass).
- Redirect (redirect_valid=1, single cycle):
  - Next cycle: queue empty, fetch_pc = redirect_pc, in-flight PC FIFO cleared.
  - drop_cnt = outstanding minus any response discarded/accepted this cycle. A response arriving in the redirect cycle is always discarded.
  - No request issues in the redirect cycle.
  - The first request to redirect_pc may issue in the cycle after redirect, even while drop_cnt > 0.
  - Responses are consumed by drop_cnt first, then by new requests, in order.
- Redirect while drop_cnt > 0: drop_cnt recomputed as the total outstanding; earlier drops are preserved.
- Reset mid-operation: all state returns to reset values the next cycle. Responses still in flight at reset are not tracked; memory is reset together with the core.
- outstanding saturates logically at MAX_OUTSTANDING; drop_cnt never underflows.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_drop_cnt[31:0].
  - perf_fetch_cnt: instructions popped by ID.
  - perf_drop_cnt: responses discarded by redirect/flush.
  - Both reset to 0, increment by 1 per event, and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, RESET_PC=0, memory always ready with 1-cycle latency, id_allow_in=1 -> requests 0x0,0x4,0x8,... back-to-back; ID sees {mem[0],0x0} two cycles after the first request, then one instruction per cycle.
- id_allow_in=0 for 10 cycles, FETCH_DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 instructions queued, inst_req_valid deasserts, no responses lost; release -> PCs 0x0..0xC delivered in order.
- Redirect to 0x100 with 2 requests outstanding (PCs 0x10,0x14) -> both responses discarded, queue flushed, next ID instruction has pc 0x100; perf_drop_cnt = 2 if enabled.
- Response arrives in the same cycle as redirect to 0x200 -> that response is discarded, drop_cnt = outstanding-1, first delivered pc = 0x200.
- Back-to-back redirects 0x300 then 0x400 with 2 outstanding -> only instructions from 0x400 reach ID.
- fetch_pc = 0xFFFFFFFC -> next request pc = 0x00000000.
